// File: rtl/apb_uart_tx.sv
// APB slave transmit-only UART: 8-entry byte FIFO feeding an 8N1 serialiser,
// with status/divisor/control registers and a level "TX drained" interrupt.
module apb_uart_tx #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic                  clk,
    input  logic                  rts,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            pstb,
    output logic                  pready,
    output logic                  perr,
    output logic                  tx,
    output logic                  irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e         state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [15:0]    timer_q, timer_d;
    logic [15:0]    bit_div_q, bit_div_d;
    logic           tx_q, tx_d;
    logic           irq_q, irq_d;
    logic [15:0]    div_q, div_d;
    logic [1:0]     ctrl_q, ctrl_d;
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [7:0]     mem_d [FIFO_DEPTH];

    logic           access, addr_ok, wr_access, tick, push, pop;
    logic           busy, full, empty;
    logic [1:0]     sel;
    logic [PTR_W:0] count;
    logic [15:0]    div_eff;
    logic           unused_bits;

    assign unused_bits = ^{paddr[ADDR_WIDTH-1:4], pwdata[DATA_WIDTH-1:16], pstb[3:2]};

    assign access    = psel & penable;
    assign addr_ok   = (paddr[1:0] == 2'b00);
    assign sel       = paddr[3:2];
    assign wr_access = access & pwrite & addr_ok;
    assign pready    = access;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign busy    = (state_q != IDLE);
    assign tick    = (timer_q == 16'd0);
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;

    // A frame starts from IDLE, or straight out of the last STOP clock so
    // back-to-back frames leave no idle gap.
    assign pop  = ctrl_q[0] & ~empty & ((state_q == IDLE) | ((state_q == STOP) & tick));
    assign push = wr_access & (sel == 2'd0) & pstb[0] & (~full | pop);

    assign perr = access & (~addr_ok
                          | (pwrite & (sel == 2'd1))
                          | (pwrite & (sel == 2'd0) & pstb[0] & full & ~pop));

    always_comb begin
        prdata = '0;
        if (access & ~pwrite & addr_ok) begin
            case (sel)
                2'd1: begin
                    prdata[0]            = busy;
                    prdata[1]            = full;
                    prdata[2]            = empty;
                    prdata[8 +: PTR_W+1] = count;
                end
                2'd2:    prdata[15:0] = div_q;
                2'd3:    prdata[1:0]  = ctrl_q;
                default: prdata       = '0;
            endcase
        end
    end

    always_comb begin
        div_d    = div_q;
        ctrl_d   = ctrl_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
        if (wr_access & (sel == 2'd2)) begin
            if (pstb[0]) div_d[7:0]  = pwdata[7:0];
            if (pstb[1]) div_d[15:8] = pwdata[15:8];
        end
        if (wr_access & (sel == 2'd3) & pstb[0]) ctrl_d = pwdata[1:0];
        if (push) mem_d[wr_ptr_q[PTR_W-1:0]] = pwdata[7:0];
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        bit_div_d = bit_div_q;
        tx_d      = tx_q;
        irq_d     = ctrl_q[1] & empty & ~busy;
        case (state_q)
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    timer_d   = bit_div_q - 16'd1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    timer_d = bit_div_q - 16'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: tx_d = 1'b1;
        endcase
        // The divisor is captured per frame so DIV writes only affect the next one.
        if (pop) begin
            state_d   = START;
            shift_d   = mem_q[rd_ptr_q[PTR_W-1:0]];
            bit_div_d = div_eff;
            timer_d   = div_eff - 16'd1;
            tx_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rts) begin
            state_q   <= IDLE;
            shift_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
            timer_q   <= 16'd0;
            bit_div_q <= 16'd1;
            tx_q      <= 1'b1;
            irq_q     <= 1'b0;
            div_q     <= DEFAULT_DIV;
            ctrl_q    <= 2'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            bit_div_q <= bit_div_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
            div_q     <= div_d;
            ctrl_q    <= ctrl_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign tx  = tx_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_apb_uart_tx.sv
// Randomised self-checking bench for apb_uart_tx; expected tx waveforms come
// from frame arithmetic over a queue of bytes written by the bench.
module tb_apb_uart_tx;

    localparam logic [31:0] A_DATA   = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_DIV    = 32'h8;
    localparam logic [31:0] A_CTRL   = 32'hC;

    logic        clk = 1'b0;
    logic        rts;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite;
    logic [3:0]  pstb;
    logic        pready, perr, tx, irq;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_bytes[$];

    always #5 clk = ~clk;

    apb_uart_tx dut (
        .clk(clk), .rts(rts), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pstb(pstb),
        .pready(pready), .perr(perr), .tx(tx), .irq(irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, output logic [31:0] rdata, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rdata = prdata;
        err   = perr;
        checkOutput("pready", {31'b0, pready}, 32'd1);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstb = 4'b0;
    endtask

    task automatic regWrite(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic exp_err);
        logic [31:0] r;
        logic        e;
        applyStimulus(1'b1, addr, data, strb, r, e);
        checkOutput("wr_perr", {31'b0, e}, {31'b0, exp_err});
    endtask

    task automatic regRead(input string tag, input logic [31:0] addr,
                           input logic [31:0] want, input logic exp_err);
        logic [31:0] r;
        logic        e;
        applyStimulus(1'b0, addr, 32'h0, 4'h0, r, e);
        checkOutput(tag, r, want);
        checkOutput({tag, "_perr"}, {31'b0, e}, {31'b0, exp_err});
    endtask

    // Each frame is 10 bit-times of div clocks: start(0), 8 data bits LSB first, stop(1).
    task automatic frameCheck(input int div, input int n);
        int         waited;
        int         f;
        int         idx;
        logic [7:0] b;
        logic       want;
        waited = 0;
        @(negedge clk);
        while (tx !== 1'b0 && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        checkOutput("start_latency", waited, 1);
        if (tx !== 1'b0) return;
        for (int t = 0; t < n * 10 * div; t++) begin
            if (t > 0) @(negedge clk);
            f    = t / (10 * div);
            idx  = (t % (10 * div)) / div;
            b    = exp_bytes[f];
            want = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : b[idx-1];
            checkOutput("tx_bit", {31'b0, tx}, {31'b0, want});
        end
        repeat (n) void'(exp_bytes.pop_front());
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         div;
        int         n;
        int         lows;

        rts = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; pstb = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_tx", {31'b0, tx}, 32'd1);
        checkOutput("rst_irq", {31'b0, irq}, 32'd0);
        checkOutput("rst_prdata", prdata, 32'd0);
        checkOutput("rst_pready", {31'b0, pready}, 32'd0);
        checkOutput("rst_perr", {31'b0, perr}, 32'd0);
        rts = 1'b0;
        regRead("rst_status", A_STATUS, 32'h004, 1'b0);
        regRead("rst_div", A_DIV, 32'd868, 1'b0);
        regRead("rst_ctrl", A_CTRL, 32'd0, 1'b0);

        // Error and strobe handling.
        regRead("misaligned_rd", 32'h2, 32'h0, 1'b1);
        regRead("misaligned_div_rd", 32'h9, 32'h0, 1'b1);
        regRead("data_rd", A_DATA, 32'h0, 1'b0);
        regWrite(A_STATUS, 32'hFFFF_FFFF, 4'hF, 1'b1);
        regRead("status_after_wr", A_STATUS, 32'h004, 1'b0);
        regWrite(A_DATA, 32'h55, 4'b0010, 1'b0);
        regRead("status_no_push", A_STATUS, 32'h004, 1'b0);
        regWrite(32'hB, 32'h3, 4'hF, 1'b1);
        regWrite(A_CTRL, 32'h1, 4'b0010, 1'b0);
        regRead("ctrl_unchanged", A_CTRL, 32'h0, 1'b0);
        regWrite(A_DIV, 32'hABCD, 4'b0010, 1'b0);
        regRead("div_hi_strobe", A_DIV, 32'hAB64, 1'b0);

        // Single frame with a mid-frame DIV write that must not disturb it.
        regWrite(A_DIV, 32'd4, 4'b0011, 1'b0);
        regWrite(A_CTRL, 32'd1, 4'b0001, 1'b0);
        exp_bytes.delete();
        exp_bytes.push_back(8'hA5);
        regWrite(A_DATA, 32'hA5, 4'b0001, 1'b0);
        fork
            frameCheck(4, 1);
            begin
                repeat (4) @(posedge clk);
                regRead("status_busy", A_STATUS, 32'h005, 1'b0);
                regWrite(A_DIV, 32'd7, 4'b0011, 1'b0);
            end
        join
        @(negedge clk);
        checkOutput("idle_tx", {31'b0, tx}, 32'd1);
        regRead("status_done", A_STATUS, 32'h004, 1'b0);
        regRead("div_readback", A_DIV, 32'd7, 1'b0);

        // DIV of zero behaves as one clock per bit.
        regWrite(A_DIV, 32'd0, 4'b0011, 1'b0);
        regRead("div_zero", A_DIV, 32'd0, 1'b0);
        exp_bytes.delete();
        exp_bytes.push_back(8'h5A);
        regWrite(A_DATA, 32'h5A, 4'b0001, 1'b0);
        frameCheck(1, 1);
        @(negedge clk);
        checkOutput("div0_idle_tx", {31'b0, tx}, 32'd1);

        // Fill the FIFO, overflow once, then drain back to back.
        regWrite(A_CTRL, 32'd0, 4'b0001, 1'b0);
        regWrite(A_DIV, 32'd3, 4'b0011, 1'b0);
        exp_bytes.delete();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            exp_bytes.push_back(b);
            regWrite(A_DATA, {24'b0, b}, 4'b0001, 1'b0);
        end
        regRead("status_full", A_STATUS, 32'h802, 1'b0);
        regWrite(A_DATA, 32'hEE, 4'b0001, 1'b1);
        regRead("status_overflow", A_STATUS, 32'h802, 1'b0);
        regWrite(A_CTRL, 32'd1, 4'b0001, 1'b0);
        frameCheck(3, 8);
        @(negedge clk);
        checkOutput("full_idle_tx", {31'b0, tx}, 32'd1);
        regRead("status_drained", A_STATUS, 32'h004, 1'b0);

        // Interrupt rises one cycle after idle+empty and drops one cycle after a push.
        regWrite(A_DIV, 32'd2, 4'b0011, 1'b0);
        regWrite(A_CTRL, 32'd3, 4'b0001, 1'b0);
        @(negedge clk);
        checkOutput("irq_latency0", {31'b0, irq}, 32'd0);
        @(negedge clk);
        checkOutput("irq_enabled", {31'b0, irq}, 32'd1);
        for (int k = 0; k < 2; k++) begin
            b = 8'($urandom);
            exp_bytes.delete();
            exp_bytes.push_back(b);
            regWrite(A_DATA, {24'b0, b}, 4'b0001, 1'b0);
            fork
                frameCheck(2, 1);
                begin
                    @(negedge clk);
                    checkOutput("irq_before_drop", {31'b0, irq}, 32'd1);
                    @(negedge clk);
                    checkOutput("irq_drop", {31'b0, irq}, 32'd0);
                end
            join
            @(negedge clk);
            checkOutput("irq_stop_done", {31'b0, irq}, 32'd0);
            @(negedge clk);
            checkOutput("irq_rise", {31'b0, irq}, 32'd1);
        end
        regWrite(A_CTRL, 32'd0, 4'b0001, 1'b0);

        // Randomised bursts.
        for (int it = 0; it < 4; it++) begin
            div = $urandom_range(1, 5);
            n   = $urandom_range(1, 8);
            regWrite(A_DIV, div, 4'b0011, 1'b0);
            exp_bytes.delete();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                exp_bytes.push_back(b);
                regWrite(A_DATA, {24'b0, b}, 4'b0001, 1'b0);
            end
            regRead("rand_status", A_STATUS, (n << 8) | ((n == 8) ? 2 : 0), 1'b0);
            regWrite(A_CTRL, 32'd1, 4'b0001, 1'b0);
            frameCheck(div, n);
            @(negedge clk);
            checkOutput("rand_idle_tx", {31'b0, tx}, 32'd1);
            regRead("rand_status_end", A_STATUS, 32'h004, 1'b0);
            regWrite(A_CTRL, 32'd0, 4'b0001, 1'b0);
        end

        // Reset during data bit 3 with bytes queued.
        regWrite(A_DIV, 32'd4, 4'b0011, 1'b0);
        exp_bytes.delete();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            exp_bytes.push_back(b);
            regWrite(A_DATA, {24'b0, b}, 4'b0001, 1'b0);
        end
        regWrite(A_CTRL, 32'd1, 4'b0001, 1'b0);
        repeat (4 * 4 + 3) @(negedge clk);
        b = exp_bytes[0];
        checkOutput("bit3_before_rst", {31'b0, tx}, {31'b0, b[3]});
        rts = 1'b1;
        @(negedge clk);
        checkOutput("midframe_rst_tx", {31'b0, tx}, 32'd1);
        rts = 1'b0;
        regRead("rst_flush_status", A_STATUS, 32'h004, 1'b0);
        regRead("rst_ctrl_cleared", A_CTRL, 32'd0, 1'b0);
        regWrite(A_CTRL, 32'd1, 4'b0001, 1'b0);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checkOutput("no_frames_after_rst", lows, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
